// File: rtl/thermo_gen_pkg.sv
// Shared types and helpers for the thermometer regenerator: code widths,
// FSM state encoding and the binary-code to thermometer mapping.
package thermo_gen_pkg;

  localparam int CODE_W   = 3;
  localparam int THERMO_W = 8;

  typedef enum logic {IDLE, HOLD} state_e;

  // Code k lights bits [k:0]; inverse of a highest-set-bit priority encoder.
  function automatic logic [THERMO_W-1:0] code2thermo(input logic [CODE_W-1:0] code);
    logic [THERMO_W-1:0] t;
    for (int i = 0; i < THERMO_W; i++) t[i] = (CODE_W'(i) <= code);
    return t;
  endfunction

endpackage

// File: rtl/thermo_gen_code_fifo.sv
// Two-entry code FIFO feeding the thermometer FSM; registered head, no bypass.
module code_fifo
  import thermo_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [CODE_W-1:0] wr_data,
  input  logic              pop,
  output logic [CODE_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  logic [CODE_W-1:0] mem_q [2];
  logic [CODE_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty   = (cnt_q == 2'd0);
  assign full    = (cnt_q == 2'd2);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/thermo_gen.sv
// Regenerates a registered thermometer comparator vector from queued ADC codes,
// holding each for hold_cycles+1 cycles, with optional auto-ramp when starved.
module thermo_gen
  import thermo_gen_pkg::*;
#(
  parameter int HOLD_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  input  logic [HOLD_W-1:0]   hold_cycles,
  input  logic                ramp_en,
  output logic [THERMO_W-1:0] cmp_out,
  output logic                cmp_valid,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [THERMO_W-1:0] cmp_out_q, cmp_out_d;
  logic                cmp_valid_q, cmp_valid_d;

  logic                pop, load, fifo_empty, fifo_full;
  logic [CODE_W-1:0]   head, load_code;

  code_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid && in_ready),
    .wr_data (in_code),
    .pop     (pop),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state_q == HOLD);
  assign cmp_out   = cmp_out_q;
  assign cmp_valid = cmp_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    cmp_out_d   = cmp_out_q;
    cmp_valid_d = cmp_valid_q;
    pop         = 1'b0;
    load        = 1'b0;
    load_code   = head;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop  = 1'b1;
        load = 1'b1;
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (!fifo_empty) begin
          pop  = 1'b1;
          load = 1'b1;
        end else if (ramp_en) begin
          load      = 1'b1;
          load_code = code_q + CODE_W'(1);
        end else begin
          // cmp_out deliberately keeps its last value when going idle
          state_d     = IDLE;
          cmp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d     = HOLD;
      code_d      = load_code;
      cmp_out_d   = code2thermo(load_code);
      cnt_d       = hold_cycles;
      cmp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      cmp_out_q   <= '0;
      cmp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      cmp_out_q   <= cmp_out_d;
      cmp_valid_q <= cmp_valid_d;
    end
  end

endmodule
